xbar_rsp_reorder: RTL and testbench
===================================

Name: xbar_rsp_reorder

Overview:
Response-side counterpart of the request crossbar matrix. The four banks return read responses out of order, each tagged with the originating channel and FIFO entry id. This block stores them per channel and hands them back to each upstream channel strictly in entry order (0..7, wrapping). Per-channel release pulses let the request side recycle entries.

Parameters:
DATA_W, 32, width of response payload
CH_NUM, 3, number of upstream channels (fixed; port list is unrolled)
BANK_NUM, 4, number of banks (fixed; port list is unrolled)
ENTRY_NUM, 8, entries per channel; entry id width 3

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous active-low reset
d_bank_k_rsp_valid  in  1  bank k response valid (k=0..3, one set per bank)
d_bank_k_rsp_ready  out  1  bank k response ready
d_bank_k_rsp_ch_id  in  2  target channel of bank k response
d_bank_k_rsp_entry_id  in  3  target entry of bank k response
d_bank_k_rsp_data  in  DATA_W  bank k response payload
u_channel_i_rsp_valid  out  1  channel i in-order response valid (i=0..2)
u_channel_i_rsp_ready  in  1  channel i response ready
u_channel_i_rsp_data  out  DATA_W  channel i response payload
ch_i_rsp_r_ptr  out  3  channel i next entry to return
ch_i_entry_release  out  1  one-cycle pulse: channel i entry at old r_ptr freed
rsp_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async assert, sync deassert): all entry valid bits 0, r_ptrs 0, u_channel_i_rsp_valid 0, release 0, rsp_err 0. Data storage is not reset.
- d_bank_k_rsp_ready is constant 1. Storage is pre-allocated by the request path, so backpressure is never applied.
- Write:
  - Bank handshake in cycle N with ch_id=c, entry_id=e sets valid[c][e] and stores the data at the cycle N clock edge.
  - Up to 4 writes per cycle, to any mix of channels.
- Read:
  - u_channel_i_rsp_valid = valid[i][r_ptr_i]; data = buf[i][r_ptr_i], a combinational mux from registers.
  - Write-to-upstream-valid latency is 1 cycle. There is no bypass.
- Pop:
  - valid & ready on channel i clears valid[i][r_ptr_i] and increments r_ptr_i (7 wraps to 0).
  - ch_i_entry_release is asserted combinationally in the same cycle (= u_channel_i handshake).
- Simultaneous events:
  - Pop of entry e and write to a different entry of the same channel in the same cycle: both take effect.
  - Write to an entry whose pre-pop valid=1 (including the entry being popped) is a collision: the write is dropped, stored data is unchanged, rsp_err is set.
  - Two or more banks targeting the same ch/entry in one cycle: the lowest bank index wins, the others are dropped, rsp_err is set.
  - ch_id=3: response dropped, rsp_err set.
- Ordering: a response at entry r_ptr+1 arriving before r_ptr is held, with u_channel_i_rsp_valid low until r_ptr fills.
- rsp_err clears only on reset.
- Reset mid-operation: all pending responses are discarded; the request side is reset in the same domain.

Decomposition:
- Package mpc_types:
  - constants XBAR_CH_NUM=3, XBAR_BANK_NUM=4, XBAR_ENTRY_NUM=8
  - typedef bank_rsp_t {ch_id[1:0], entry_id[2:0], data[DATA_W-1:0]}
- Sub-module xbar_rsp_ch_buf, instantiated once per channel:
  - 8-entry valid/data array with 4 write ports, r_ptr, pop logic, per-port collision detect.
  - The top level does bank-to-channel demux, same-entry priority among banks, and the error OR.

Test Plan:
- In-order single: bank 2 returns ch0/entry0 data 0xA5A5_0001; channel 0 ready=1 -> u_channel_0_rsp_valid high 1 cycle later with 0xA5A5_0001, release pulse, r_ptr 0->1.
- Out-of-order: ch1 entries 2,1,0 arrive on consecutive cycles from banks 3,1,0 -> no ch1 valid until entry0 is written; then 3 consecutive pops in order 0,1,2; r_ptr ends at 3.
- Wrap and backpressure: fill ch2 entries 0..7 with ready=0 -> valid held, data stable. Release ready -> 8 pops, r_ptr wraps 7->0; refill entry0 -> accepted, no error.
- Parallel banks: all 4 banks write ch0 entries 4..7 in one cycle while ch0 pops entry 3 -> all stored, pop completes, rsp_err=0.
- Errors:
  - banks 1 and 2 both target ch1/entry5 -> bank 1 data stored, rsp_err=1.
  - write to already-valid ch0/entry0 -> data unchanged.
  - ch_id=3 -> dropped.
- Async reset asserted with 5 pending entries -> all valids 0, r_ptrs 0, rsp_err 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mpc_types.sv
// Shared constants and the bank response record for the response reorder path.
package mpc_types;
  localparam int XBAR_CH_NUM    = 3;
  localparam int XBAR_BANK_NUM  = 4;
  localparam int XBAR_ENTRY_NUM = 8;
  localparam int XBAR_DATA_W    = 32;

  typedef struct packed {
    logic [1:0]             ch_id;
    logic [2:0]             entry_id;
    logic [XBAR_DATA_W-1:0] data;
  } bank_rsp_t;
endpackage

// File: rtl/xbar_rsp_ch_buf.sv
// Per-channel 8-entry reorder buffer: 4 write ports, in-order pop at r_ptr.
// Write-to-valid latency 1 cycle; writes never stall, a write to a busy entry is dropped and flagged.
module xbar_rsp_ch_buf
  import mpc_types::*;
#(
  parameter int DATA_W = XBAR_DATA_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [XBAR_BANK_NUM-1:0]               wr_en,
  input  logic [XBAR_BANK_NUM-1:0][2:0]          wr_entry,
  input  logic [XBAR_BANK_NUM-1:0][DATA_W-1:0]   wr_data,
  output logic                                   rsp_vld,
  input  logic                                   rsp_rdy,
  output logic [DATA_W-1:0]                      rsp_dat,
  output logic [2:0]                             r_ptr,
  output logic                                   entry_release,
  output logic                                   wr_collision
);
  logic [XBAR_ENTRY_NUM-1:0]             valid_q, valid_d;
  logic [XBAR_ENTRY_NUM-1:0][DATA_W-1:0] buf_q, buf_d;
  logic [2:0]                            r_ptr_q, r_ptr_d;
  logic                                  pop;

  assign rsp_vld       = valid_q[r_ptr_q];
  assign rsp_dat       = buf_q[r_ptr_q];
  assign pop           = rsp_vld & rsp_rdy;
  assign entry_release = pop;
  assign r_ptr         = r_ptr_q;

  // Collision is judged on the pre-pop valid bits, so writing the entry being popped is an error.
  always_comb begin
    valid_d      = valid_q;
    buf_d        = buf_q;
    r_ptr_d      = r_ptr_q;
    wr_collision = 1'b0;
    if (pop) begin
      valid_d[r_ptr_q] = 1'b0;
      r_ptr_d          = r_ptr_q + 3'd1;
    end
    for (int k = 0; k < XBAR_BANK_NUM; k++) begin
      if (wr_en[k]) begin
        if (valid_q[wr_entry[k]]) begin
          wr_collision = 1'b1;
        end else begin
          valid_d[wr_entry[k]] = 1'b1;
          buf_d[wr_entry[k]]   = wr_data[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      r_ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      r_ptr_q <= r_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end
endmodule

// File: rtl/xbar_rsp_reorder.sv
// Returns out-of-order bank responses to each upstream channel strictly in entry order.
// Write-to-upstream-valid latency 1 cycle; bank ready is constant 1, upstream backpressure only holds data.
module xbar_rsp_reorder
  import mpc_types::*;
#(
  parameter int DATA_W = XBAR_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d_bank_0_rsp_valid,
  output logic              d_bank_0_rsp_ready,
  input  logic [1:0]        d_bank_0_rsp_ch_id,
  input  logic [2:0]        d_bank_0_rsp_entry_id,
  input  logic [DATA_W-1:0] d_bank_0_rsp_data,
  input  logic              d_bank_1_rsp_valid,
  output logic              d_bank_1_rsp_ready,
  input  logic [1:0]        d_bank_1_rsp_ch_id,
  input  logic [2:0]        d_bank_1_rsp_entry_id,
  input  logic [DATA_W-1:0] d_bank_1_rsp_data,
  input  logic              d_bank_2_rsp_valid,
  output logic              d_bank_2_rsp_ready,
  input  logic [1:0]        d_bank_2_rsp_ch_id,
  input  logic [2:0]        d_bank_2_rsp_entry_id,
  input  logic [DATA_W-1:0] d_bank_2_rsp_data,
  input  logic              d_bank_3_rsp_valid,
  output logic              d_bank_3_rsp_ready,
  input  logic [1:0]        d_bank_3_rsp_ch_id,
  input  logic [2:0]        d_bank_3_rsp_entry_id,
  input  logic [DATA_W-1:0] d_bank_3_rsp_data,
  output logic              u_channel_0_rsp_valid,
  input  logic              u_channel_0_rsp_ready,
  output logic [DATA_W-1:0] u_channel_0_rsp_data,
  output logic              u_channel_1_rsp_valid,
  input  logic              u_channel_1_rsp_ready,
  output logic [DATA_W-1:0] u_channel_1_rsp_data,
  output logic              u_channel_2_rsp_valid,
  input  logic              u_channel_2_rsp_ready,
  output logic [DATA_W-1:0] u_channel_2_rsp_data,
  output logic [2:0]        ch_0_rsp_r_ptr,
  output logic [2:0]        ch_1_rsp_r_ptr,
  output logic [2:0]        ch_2_rsp_r_ptr,
  output logic              ch_0_entry_release,
  output logic              ch_1_entry_release,
  output logic              ch_2_entry_release,
  output logic              rsp_err
);
  bank_rsp_t [XBAR_BANK_NUM-1:0]              bank_rsp;
  logic [XBAR_BANK_NUM-1:0]                   bank_vld, bank_keep;
  logic [XBAR_BANK_NUM-1:0][2:0]              bank_entry;
  logic [XBAR_BANK_NUM-1:0][DATA_W-1:0]       bank_dat;
  logic [XBAR_CH_NUM-1:0][XBAR_BANK_NUM-1:0]  ch_wr_en;
  logic [XBAR_CH_NUM-1:0]                     ch_vld, ch_rdy, ch_rel, ch_coll;
  logic [XBAR_CH_NUM-1:0][DATA_W-1:0]         ch_dat;
  logic [XBAR_CH_NUM-1:0][2:0]                ch_rptr;
  logic                                       drop_err;
  logic                                       rsp_err_q, rsp_err_d;

  assign bank_vld    = {d_bank_3_rsp_valid, d_bank_2_rsp_valid, d_bank_1_rsp_valid, d_bank_0_rsp_valid};
  assign bank_rsp[0] = '{ch_id: d_bank_0_rsp_ch_id, entry_id: d_bank_0_rsp_entry_id, data: d_bank_0_rsp_data};
  assign bank_rsp[1] = '{ch_id: d_bank_1_rsp_ch_id, entry_id: d_bank_1_rsp_entry_id, data: d_bank_1_rsp_data};
  assign bank_rsp[2] = '{ch_id: d_bank_2_rsp_ch_id, entry_id: d_bank_2_rsp_entry_id, data: d_bank_2_rsp_data};
  assign bank_rsp[3] = '{ch_id: d_bank_3_rsp_ch_id, entry_id: d_bank_3_rsp_entry_id, data: d_bank_3_rsp_data};

  assign d_bank_0_rsp_ready = 1'b1;
  assign d_bank_1_rsp_ready = 1'b1;
  assign d_bank_2_rsp_ready = 1'b1;
  assign d_bank_3_rsp_ready = 1'b1;

  // A bank survives unless it targets channel 3 or a lower bank already claims the same ch/entry.
  always_comb begin
    bank_keep = '0;
    ch_wr_en  = '0;
    drop_err  = 1'b0;
    for (int k = 0; k < XBAR_BANK_NUM; k++) begin
      bank_entry[k] = bank_rsp[k].entry_id;
      bank_dat[k]   = bank_rsp[k].data;
      if (bank_vld[k]) begin
        bank_keep[k] = (bank_rsp[k].ch_id != 2'd3);
        for (int j = 0; j < k; j++) begin
          if (bank_vld[j] && (bank_rsp[j].ch_id == bank_rsp[k].ch_id) &&
              (bank_rsp[j].entry_id == bank_rsp[k].entry_id)) begin
            bank_keep[k] = 1'b0;
          end
        end
        if (!bank_keep[k]) drop_err = 1'b1;
      end
      for (int c = 0; c < XBAR_CH_NUM; c++) begin
        ch_wr_en[c][k] = bank_keep[k] && (bank_rsp[k].ch_id == 2'(c));
      end
    end
  end

  assign ch_rdy = {u_channel_2_rsp_ready, u_channel_1_rsp_ready, u_channel_0_rsp_ready};

  for (genvar c = 0; c < XBAR_CH_NUM; c++) begin : g_ch
    xbar_rsp_ch_buf #(.DATA_W(DATA_W)) u_buf (
      .clk           (clk),
      .rst_n         (rst_n),
      .wr_en         (ch_wr_en[c]),
      .wr_entry      (bank_entry),
      .wr_data       (bank_dat),
      .rsp_vld       (ch_vld[c]),
      .rsp_rdy       (ch_rdy[c]),
      .rsp_dat       (ch_dat[c]),
      .r_ptr         (ch_rptr[c]),
      .entry_release (ch_rel[c]),
      .wr_collision  (ch_coll[c])
    );
  end

  assign u_channel_0_rsp_valid = ch_vld[0];
  assign u_channel_1_rsp_valid = ch_vld[1];
  assign u_channel_2_rsp_valid = ch_vld[2];
  assign u_channel_0_rsp_data  = ch_dat[0];
  assign u_channel_1_rsp_data  = ch_dat[1];
  assign u_channel_2_rsp_data  = ch_dat[2];
  assign ch_0_rsp_r_ptr        = ch_rptr[0];
  assign ch_1_rsp_r_ptr        = ch_rptr[1];
  assign ch_2_rsp_r_ptr        = ch_rptr[2];
  assign ch_0_entry_release    = ch_rel[0];
  assign ch_1_entry_release    = ch_rel[1];
  assign ch_2_entry_release    = ch_rel[2];

  assign rsp_err_d = rsp_err_q | drop_err | (|ch_coll);
  assign rsp_err   = rsp_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err_q <= 1'b0;
    else        rsp_err_q <= rsp_err_d;
  end
endmodule

// File: tb/tb_xbar_rsp_reorder.sv
// Bench for xbar_rsp_reorder: directed vector table, corner sequences and a randomized run vs a reference model.
module tb_xbar_rsp_reorder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        b_vld [4];
  logic [1:0]  b_ch  [4];
  logic [2:0]  b_ent [4];
  logic [31:0] b_dat [4];
  logic        b_rdy [4];
  logic        u_rdy [3];
  logic        u_vld [3];
  logic [31:0] u_dat [3];
  logic [2:0]  rptr  [3];
  logic        rel   [3];
  logic        err;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  xbar_rsp_reorder #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_bank_0_rsp_valid(b_vld[0]), .d_bank_0_rsp_ready(b_rdy[0]), .d_bank_0_rsp_ch_id(b_ch[0]),
    .d_bank_0_rsp_entry_id(b_ent[0]), .d_bank_0_rsp_data(b_dat[0]),
    .d_bank_1_rsp_valid(b_vld[1]), .d_bank_1_rsp_ready(b_rdy[1]), .d_bank_1_rsp_ch_id(b_ch[1]),
    .d_bank_1_rsp_entry_id(b_ent[1]), .d_bank_1_rsp_data(b_dat[1]),
    .d_bank_2_rsp_valid(b_vld[2]), .d_bank_2_rsp_ready(b_rdy[2]), .d_bank_2_rsp_ch_id(b_ch[2]),
    .d_bank_2_rsp_entry_id(b_ent[2]), .d_bank_2_rsp_data(b_dat[2]),
    .d_bank_3_rsp_valid(b_vld[3]), .d_bank_3_rsp_ready(b_rdy[3]), .d_bank_3_rsp_ch_id(b_ch[3]),
    .d_bank_3_rsp_entry_id(b_ent[3]), .d_bank_3_rsp_data(b_dat[3]),
    .u_channel_0_rsp_valid(u_vld[0]), .u_channel_0_rsp_ready(u_rdy[0]), .u_channel_0_rsp_data(u_dat[0]),
    .u_channel_1_rsp_valid(u_vld[1]), .u_channel_1_rsp_ready(u_rdy[1]), .u_channel_1_rsp_data(u_dat[1]),
    .u_channel_2_rsp_valid(u_vld[2]), .u_channel_2_rsp_ready(u_rdy[2]), .u_channel_2_rsp_data(u_dat[2]),
    .ch_0_rsp_r_ptr(rptr[0]), .ch_1_rsp_r_ptr(rptr[1]), .ch_2_rsp_r_ptr(rptr[2]),
    .ch_0_entry_release(rel[0]), .ch_1_entry_release(rel[1]), .ch_2_entry_release(rel[2]),
    .rsp_err(err)
  );

  // Reference model: per channel a set of stored responses and the next sequence number to hand out.
  bit          m_valid [3][8];
  logic [31:0] m_data  [3][8];
  int          m_ptr   [3];
  bit          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      m_ptr[c] = 0;
      for (int e = 0; e < 8; e++) m_valid[c][e] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic model_check();
    for (int c = 0; c < 3; c++) begin
      bit ev;
      ev = m_valid[c][m_ptr[c]];
      chk($sformatf("m_ch%0d_vld", c), {31'd0, u_vld[c]}, {31'd0, ev});
      if (ev) chk($sformatf("m_ch%0d_dat", c), u_dat[c], m_data[c][m_ptr[c]]);
      chk($sformatf("m_ch%0d_rel", c), {31'd0, rel[c]}, {31'd0, ev & u_rdy[c]});
      chk($sformatf("m_ch%0d_ptr", c), {29'd0, rptr[c]}, 32'(m_ptr[c]));
    end
    chk("m_err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic model_update();
    bit pre  [3][8];
    bit seen [3][8];
    pre = m_valid;
    for (int c = 0; c < 3; c++) for (int e = 0; e < 8; e++) seen[c][e] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (b_vld[k]) begin
        int c, e;
        c = int'(b_ch[k]);
        e = int'(b_ent[k]);
        if (c == 3) m_err = 1'b1;
        else if (seen[c][e]) m_err = 1'b1;
        else begin
          seen[c][e] = 1'b1;
          if (pre[c][e]) m_err = 1'b1;
          else begin
            m_valid[c][e] = 1'b1;
            m_data[c][e]  = b_dat[k];
          end
        end
      end
    end
    for (int c = 0; c < 3; c++) begin
      if (pre[c][m_ptr[c]] && u_rdy[c]) begin
        m_valid[c][m_ptr[c]] = 1'b0;
        m_ptr[c] = (m_ptr[c] + 1) % 8;
      end
    end
  endtask

  // Called at posedge+4: compare, advance model, move to posedge+1 for the next drive.
  task automatic cycle_check();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #3;
    cycle_check();
  endtask

  task automatic idle(input logic [2:0] rdy);
    for (int k = 0; k < 4; k++) begin
      b_vld[k] = 1'b0; b_ch[k] = '0; b_ent[k] = '0; b_dat[k] = '0;
    end
    for (int c = 0; c < 3; c++) u_rdy[c] = rdy[c];
  endtask

  task automatic bank(input int k, input logic [1:0] c, input logic [2:0] e, input logic [31:0] d);
    b_vld[k] = 1'b1; b_ch[k] = c; b_ent[k] = e; b_dat[k] = d;
  endtask

  typedef struct {
    logic [3:0]        bv;
    logic [3:0][1:0]   bc;
    logic [3:0][2:0]   be;
    logic [3:0][31:0]  bd;
    logic [2:0]        rdy;
    logic [2:0]        ev;
    logic [2:0]        er;
    logic              ee;
    int                dch;
    logic [31:0]       ed;
    logic [2:0][2:0]   p;
  } vec_t;

  vec_t tbl [40];
  int   ntbl = 0;

  task automatic row(input logic [2:0] rdy, input logic [2:0] ev, input logic [2:0] er, input logic ee,
                     input int dch, input logic [31:0] ed, input logic [2:0] p0, input logic [2:0] p1,
                     input logic [2:0] p2);
    vec_t v;
    v.bv = '0; v.bc = '0; v.be = '0; v.bd = '0;
    v.rdy = rdy; v.ev = ev; v.er = er; v.ee = ee; v.dch = dch; v.ed = ed;
    v.p[0] = p0; v.p[1] = p1; v.p[2] = p2;
    tbl[ntbl] = v;
    ntbl++;
  endtask

  task automatic bw(input int k, input logic [1:0] c, input logic [2:0] e, input logic [31:0] d);
    tbl[ntbl-1].bv[k] = 1'b1;
    tbl[ntbl-1].bc[k] = c;
    tbl[ntbl-1].be[k] = e;
    tbl[ntbl-1].bd[k] = d;
  endtask

  task automatic rand_drive(input bit clean);
    bit used [3][8];
    used = m_valid;
    for (int c = 0; c < 3; c++) u_rdy[c] = ($urandom_range(0, 9) < 7);
    for (int k = 0; k < 4; k++) begin
      b_vld[k] = 1'b0; b_ch[k] = '0; b_ent[k] = '0; b_dat[k] = $urandom;
      if ($urandom_range(0, 9) < 6) begin
        int c, e;
        c = $urandom_range(0, 2);
        e = (m_ptr[c] + $urandom_range(0, 3)) % 8;
        if (!clean && $urandom_range(0, 19) == 0) c = 3;
        if (!clean || !used[c][e]) begin
          if (c < 3) used[c][e] = 1'b1;
          bank(k, 2'(c), 3'(e), $urandom);
        end
      end
    end
  endtask

  function automatic logic [2:0] vld3();
    return {u_vld[2], u_vld[1], u_vld[0]};
  endfunction

  function automatic logic [2:0] rel3();
    return {rel[2], rel[1], rel[0]};
  endfunction

  initial begin
    // In-order single, out-of-order ch1, parallel banks with pop, duplicate/collision/ch3 errors.
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 0, 0, 0); bw(2, 0, 0, 32'hA5A5_0001);
    row(3'b111, 3'b001, 3'b001, 0,  0, 32'hA5A5_0001, 0, 0, 0);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 1, 0, 0);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 1, 0, 0); bw(3, 1, 2, 32'h1111_0002);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 1, 0, 0); bw(1, 1, 1, 32'h1111_0001);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 1, 0, 0); bw(0, 1, 0, 32'h1111_0000);
    row(3'b111, 3'b010, 3'b010, 0,  1, 32'h1111_0000, 1, 0, 0);
    row(3'b111, 3'b010, 3'b010, 0,  1, 32'h1111_0001, 1, 1, 0);
    row(3'b111, 3'b010, 3'b010, 0,  1, 32'h1111_0002, 1, 2, 0);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 1, 3, 0);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 1, 3, 0);
    bw(0, 0, 1, 32'hC0C0_0001); bw(1, 0, 2, 32'hC0C0_0002); bw(2, 0, 3, 32'hC0C0_0003);
    row(3'b111, 3'b001, 3'b001, 0,  0, 32'hC0C0_0001, 1, 3, 0);
    row(3'b111, 3'b001, 3'b001, 0,  0, 32'hC0C0_0002, 2, 3, 0);
    row(3'b111, 3'b001, 3'b001, 0,  0, 32'hC0C0_0003, 3, 3, 0);
    for (int k = 0; k < 4; k++) bw(k, 0, 3'(4 + k), 32'hC0C0_0004 + 32'(k));
    for (int k = 4; k < 8; k++) row(3'b111, 3'b001, 3'b001, 0, 0, 32'hC0C0_0000 + 32'(k), 3'(k), 3, 0);
    row(3'b111, 3'b000, 3'b000, 0, -1, 0, 0, 3, 0);
    row(3'b101, 3'b000, 3'b000, 0, -1, 0, 0, 3, 0);
    bw(1, 1, 3, 32'hBBBB_0001); bw(2, 1, 3, 32'hBBBB_0002);
    row(3'b101, 3'b010, 3'b000, 1,  1, 32'hBBBB_0001, 0, 3, 0);
    row(3'b101, 3'b010, 3'b000, 1,  1, 32'hBBBB_0001, 0, 3, 0); bw(0, 1, 3, 32'hDEAD_0000);
    row(3'b111, 3'b010, 3'b010, 1,  1, 32'hBBBB_0001, 0, 3, 0);
    row(3'b111, 3'b000, 3'b000, 1, -1, 0, 0, 4, 0); bw(0, 3, 0, 32'hEEEE_0000);
    row(3'b111, 3'b000, 3'b000, 1, -1, 0, 0, 4, 0);

    rst_n = 1'b0;
    idle(3'b000);
    model_reset();
    #12;
    chk("rst_vld", {29'd0, vld3()}, 32'd0);
    chk("rst_rel", {29'd0, rel3()}, 32'd0);
    chk("rst_ptr", {23'd0, rptr[2], rptr[1], rptr[0]}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("bank_rdy", {28'd0, b_rdy[3], b_rdy[2], b_rdy[1], b_rdy[0]}, 32'hF);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < ntbl; i++) begin
      for (int k = 0; k < 4; k++) begin
        b_vld[k] = tbl[i].bv[k]; b_ch[k] = tbl[i].bc[k]; b_ent[k] = tbl[i].be[k]; b_dat[k] = tbl[i].bd[k];
      end
      for (int c = 0; c < 3; c++) u_rdy[c] = tbl[i].rdy[c];
      #3;
      chk($sformatf("v%0d_vld", i), {29'd0, vld3()}, {29'd0, tbl[i].ev});
      chk($sformatf("v%0d_rel", i), {29'd0, rel3()}, {29'd0, tbl[i].er});
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, tbl[i].ee});
      chk($sformatf("v%0d_ptr", i), {23'd0, rptr[2], rptr[1], rptr[0]}, {23'd0, tbl[i].p});
      if (tbl[i].dch >= 0) chk($sformatf("v%0d_dat", i), u_dat[tbl[i].dch], tbl[i].ed);
      cycle_check();
    end

    // Async reset with pending entries: everything clears before any clock edge.
    idle(3'b000);
    for (int k = 0; k < 4; k++) bank(k, 2, 3'(k), 32'h2222_0000 + 32'(k));
    step();
    idle(3'b000);
    bank(0, 1, 4, 32'h1111_0004);
    step();
    idle(3'b000);
    #2;
    chk("pre_rst_vld", {29'd0, vld3()}, 32'b110);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", {29'd0, vld3()}, 32'd0);
    chk("arst_ptr", {23'd0, rptr[2], rptr[1], rptr[0]}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ch2 fill under backpressure, drain with wrap, refill entry 0 cleanly.
    idle(3'b000);
    for (int k = 0; k < 4; k++) bank(k, 2, 3'(k), 32'h3333_0000 + 32'(k));
    step();
    idle(3'b000);
    for (int k = 0; k < 4; k++) bank(k, 2, 3'(4 + k), 32'h3333_0004 + 32'(k));
    step();
    for (int n = 0; n < 3; n++) begin
      idle(3'b000);
      #3;
      chk("hold_vld", {31'd0, u_vld[2]}, 32'd1);
      chk("hold_dat", u_dat[2], 32'h3333_0000);
      cycle_check();
    end
    for (int n = 0; n < 8; n++) begin
      idle(3'b100);
      step();
    end
    chk("wrap_ptr", {29'd0, rptr[2]}, 32'd0);
    idle(3'b100);
    bank(1, 2, 0, 32'h4444_0000);
    step();
    idle(3'b000);
    #3;
    chk("refill_vld", {31'd0, u_vld[2]}, 32'd1);
    chk("refill_dat", u_dat[2], 32'h4444_0000);
    chk("refill_err", {31'd0, err}, 32'd0);
    cycle_check();

    // Lone ch_id=3 response is dropped and raises the sticky error.
    idle(3'b111);
    bank(2, 3, 0, 32'h5555_0000);
    step();
    idle(3'b111);
    #3;
    chk("ch3_err", {31'd0, err}, 32'd1);
    chk("ch3_vld", {29'd0, vld3()}, 32'd0);
    cycle_check();

    // Randomized traffic: collision-free first (error must stay low), then with errors mixed in.
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 0; n < 1500; n++) begin
      rand_drive(1'b1);
      step();
    end
    for (int n = 0; n < 500; n++) begin
      rand_drive(1'b0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
